// File: rtl/sump_cmd_decoder.sv
// SUMP host command framer: splits the byte stream into short (1-byte) and
// long (opcode + 4-byte LSB-first argument) commands and emits one-cycle strobes.
module sump_cmd_decoder #(
  parameter int TIMEOUT = 100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  opcode,
  output logic [31:0] config_data,
  output logic        wrDivider,
  output logic        wrSize,
  output logic        wrFlags,
  output logic [3:0]  wrTrigMask,
  output logic [3:0]  wrTrigValue,
  output logic [3:0]  wrTrigConfig,
  output logic        cmd_reset,
  output logic        cmd_arm,
  output logic        cmd_id,
  output logic        cmd_meta,
  output logic        finish_now,
  output logic        xon,
  output logic        xoff,
  output logic        frame_drop
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Drop fires on the idle edge that would carry the counter to TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt;
  logic [7:0]      pend;
  logic [3:0][7:0] arg;

  always_ff @(posedge clock) begin
    wrDivider    <= 1'b0;
    wrSize       <= 1'b0;
    wrFlags      <= 1'b0;
    wrTrigMask   <= '0;
    wrTrigValue  <= '0;
    wrTrigConfig <= '0;
    cmd_reset    <= 1'b0;
    cmd_arm      <= 1'b0;
    cmd_id       <= 1'b0;
    cmd_meta     <= 1'b0;
    finish_now   <= 1'b0;
    xon          <= 1'b0;
    xoff         <= 1'b0;
    frame_drop   <= 1'b0;
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      pend        <= '0;
      arg         <= '0;
      opcode      <= '0;
      config_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            if (!rx_data[7]) begin
              opcode <= rx_data;
              case (rx_data)
                8'h00:   cmd_reset  <= 1'b1;
                8'h01:   cmd_arm    <= 1'b1;
                8'h02:   cmd_id     <= 1'b1;
                8'h04:   cmd_meta   <= 1'b1;
                8'h05:   finish_now <= 1'b1;
                8'h11:   xon        <= 1'b1;
                8'h13:   xoff       <= 1'b1;
                default: ;
              endcase
            end else begin
              pend  <= rx_data;
              idx   <= '0;
              cnt   <= '0;
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            arg[idx] <= rx_data;
            idx      <= idx + 2'd1;
            cnt      <= '0;
            if (idx == 2'd3) begin
              config_data <= {rx_data, arg[2], arg[1], arg[0]};
              opcode      <= pend;
              state       <= IDLE;
              case (pend)
                8'h80: wrDivider <= 1'b1;
                8'h81: wrSize    <= 1'b1;
                8'h82: wrFlags   <= 1'b1;
                default: begin
                  // 0xC0..0xCF: bits [3:2] pick the stage, [1:0] the register.
                  if (pend[7:4] == 4'hC) begin
                    case (pend[1:0])
                      2'd0:    wrTrigMask   <= 4'b0001 << pend[3:2];
                      2'd1:    wrTrigValue  <= 4'b0001 << pend[3:2];
                      2'd2:    wrTrigConfig <= 4'b0001 << pend[3:2];
                      default: ;
                    endcase
                  end
                end
              endcase
            end
          end else if (TIMEOUT != 0) begin
            if (cnt == CNT_LAST) begin
              frame_drop <= 1'b1;
              arg        <= '0;
              idx        <= '0;
              cnt        <= '0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: directed vector table, timeout corner sequences,
// and randomized framing traffic checked against a queue-based protocol model.
module tb_sump_cmd_decoder;
  localparam int TO = 16;

  localparam logic [22:0] S_DROP = 23'(1) << 0;
  localparam logic [22:0] S_XOFF = 23'(1) << 1;
  localparam logic [22:0] S_XON  = 23'(1) << 2;
  localparam logic [22:0] S_FIN  = 23'(1) << 3;
  localparam logic [22:0] S_META = 23'(1) << 4;
  localparam logic [22:0] S_ID   = 23'(1) << 5;
  localparam logic [22:0] S_ARM  = 23'(1) << 6;
  localparam logic [22:0] S_RST  = 23'(1) << 7;
  localparam logic [22:0] S_TV1  = 23'(1) << 13;
  localparam logic [22:0] S_FLG  = 23'(1) << 20;
  localparam logic [22:0] S_SIZ  = 23'(1) << 21;
  localparam logic [22:0] S_DIV  = 23'(1) << 22;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [7:0] opcode;
  logic [31:0] config_data;
  logic wrDivider, wrSize, wrFlags;
  logic [3:0] wrTrigMask, wrTrigValue, wrTrigConfig;
  logic cmd_reset, cmd_arm, cmd_id, cmd_meta, finish_now, xon, xoff, frame_drop;

  sump_cmd_decoder #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .opcode(opcode), .config_data(config_data),
    .wrDivider(wrDivider), .wrSize(wrSize), .wrFlags(wrFlags),
    .wrTrigMask(wrTrigMask), .wrTrigValue(wrTrigValue), .wrTrigConfig(wrTrigConfig),
    .cmd_reset(cmd_reset), .cmd_arm(cmd_arm), .cmd_id(cmd_id), .cmd_meta(cmd_meta),
    .finish_now(finish_now), .xon(xon), .xoff(xoff), .frame_drop(frame_drop)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame is just a queue of bytes; idle counts quiet cycles.
  bit          m_in_frame = 0;
  logic [7:0]  m_q[$];
  int          m_idle = 0;
  logic [7:0]  m_op = '0;
  logic [31:0] m_cfg = '0;
  logic [22:0] m_stb = '0;

  function automatic logic [22:0] dut_stb();
    return {wrDivider, wrSize, wrFlags, wrTrigMask, wrTrigValue, wrTrigConfig,
            cmd_reset, cmd_arm, cmd_id, cmd_meta, finish_now, xon, xoff, frame_drop};
  endfunction

  function automatic logic [22:0] short_stb(logic [7:0] b);
    case (b)
      8'h00: return S_RST;
      8'h01: return S_ARM;
      8'h02: return S_ID;
      8'h04: return S_META;
      8'h05: return S_FIN;
      8'h11: return S_XON;
      8'h13: return S_XOFF;
      default: return '0;
    endcase
  endfunction

  function automatic logic [22:0] long_stb(logic [7:0] b);
    int v, n, kind;
    v = int'(b);
    if (v == 128) return S_DIV;
    if (v == 129) return S_SIZ;
    if (v == 130) return S_FLG;
    if (v >= 192 && v <= 207) begin
      n = (v - 192) / 4;
      kind = (v - 192) % 4;
      if (kind == 0) return 23'(1) << (16 + n);
      if (kind == 1) return 23'(1) << (12 + n);
      if (kind == 2) return 23'(1) << (8 + n);
    end
    return '0;
  endfunction

  task automatic model(bit r, bit v, logic [7:0] d);
    m_stb = '0;
    if (!r) begin
      m_op = '0; m_cfg = '0; m_q.delete(); m_in_frame = 0; m_idle = 0;
    end else if (!m_in_frame) begin
      if (v) begin
        if (d < 8'h80) begin
          m_op = d;
          m_stb = short_stb(d);
        end else begin
          m_in_frame = 1; m_q.delete(); m_q.push_back(d); m_idle = 0;
        end
      end
    end else if (v) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == 5) begin
        m_op = m_q[0];
        m_cfg = {m_q[4], m_q[3], m_q[2], m_q[1]};
        m_stb = long_stb(m_q[0]);
        m_in_frame = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_stb = S_DROP;
        m_in_frame = 0;
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // One clock: drive, let the edge sample, advance the model, compare after the edge.
  task automatic step(bit r, bit v, logic [7:0] d);
    reset_n = r; rx_valid = v; rx_data = d;
    @(posedge clock);
    model(r, v, d);
    #1;
    chk("model_stb", 64'(dut_stb()), 64'(m_stb));
    chk("model_op",  64'(opcode), 64'(m_op));
    chk("model_cfg", 64'(config_data), 64'(m_cfg));
    chk("onehot", 64'($countones(dut_stb()) > 1), 64'(0));
  endtask

  typedef struct {
    bit          r;
    bit          v;
    logic [7:0]  d;
    logic [22:0] stb;
    logic [7:0]  op;
    logic [31:0] cfg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit v, logic [7:0] d, logic [22:0] stb,
                              logic [7:0] op, logic [31:0] cfg);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.stb = stb; x.op = op; x.cfg = cfg;
    return x;
  endfunction

  initial begin
    // reset, wrFlags frame, short commands with gaps
    tbl.push_back(mk(0, 0, 8'h00, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h82, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h78, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h56, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h34, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h12, S_FLG, 8'h82, 32'h12345678));
    tbl.push_back(mk(1, 0, 8'h00, 0,     8'h82, 32'h12345678));
    tbl.push_back(mk(1, 1, 8'h01, S_ARM, 8'h01, 32'h12345678));
    tbl.push_back(mk(1, 0, 8'h00, 0,     8'h01, 32'h12345678));
    tbl.push_back(mk(1, 1, 8'h05, S_FIN, 8'h05, 32'h12345678));
    tbl.push_back(mk(1, 0, 8'h00, 0,     8'h05, 32'h12345678));
    tbl.push_back(mk(1, 1, 8'h11, S_XON, 8'h11, 32'h12345678));
    tbl.push_back(mk(1, 0, 8'h00, 0,     8'h11, 32'h12345678));
    tbl.push_back(mk(1, 1, 8'h07, 0,     8'h07, 32'h12345678));
    // 0x00 inside a frame is data
    tbl.push_back(mk(1, 1, 8'hC5, 0,     8'h07, 32'h12345678));
    tbl.push_back(mk(1, 1, 8'h00, 0,     8'h07, 32'h12345678));
    tbl.push_back(mk(1, 1, 8'h00, 0,     8'h07, 32'h12345678));
    tbl.push_back(mk(1, 1, 8'h00, 0,     8'h07, 32'h12345678));
    tbl.push_back(mk(1, 1, 8'h00, S_TV1, 8'hC5, 32'h0));
    // unknown long opcode keeps framing
    tbl.push_back(mk(1, 1, 8'h83, 0,     8'hC5, 32'h0));
    tbl.push_back(mk(1, 1, 8'hAA, 0,     8'hC5, 32'h0));
    tbl.push_back(mk(1, 1, 8'hBB, 0,     8'hC5, 32'h0));
    tbl.push_back(mk(1, 1, 8'hCC, 0,     8'hC5, 32'h0));
    tbl.push_back(mk(1, 1, 8'hDD, 0,     8'h83, 32'hDDCCBBAA));
    tbl.push_back(mk(1, 1, 8'h01, S_ARM, 8'h01, 32'hDDCCBBAA));
    // reset mid-frame aborts silently
    tbl.push_back(mk(1, 1, 8'h80, 0,     8'h01, 32'hDDCCBBAA));
    tbl.push_back(mk(1, 1, 8'h11, 0,     8'h01, 32'hDDCCBBAA));
    tbl.push_back(mk(0, 0, 8'h00, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h80, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h01, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h00, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h00, 0,     8'h00, 32'h0));
    tbl.push_back(mk(1, 1, 8'h00, S_DIV, 8'h80, 32'h00000001));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_stb", i), 64'(dut_stb()), 64'(tbl[i].stb));
      chk($sformatf("tbl%0d_op", i),  64'(opcode), 64'(tbl[i].op));
      chk($sformatf("tbl%0d_cfg", i), 64'(config_data), 64'(tbl[i].cfg));
    end

    // Timeout: drop on the 16th quiet edge after the last byte.
    step(1, 1, 8'h81);
    step(1, 1, 8'hAA);
    for (int i = 1; i < TO; i++) begin
      step(1, 0, 8'h00);
      chk("to_no_early_drop", 64'(frame_drop), 64'(0));
    end
    step(1, 0, 8'h00);
    chk("to_drop", 64'(dut_stb()), 64'(S_DROP));
    chk("to_drop_op", 64'(opcode), 64'(8'h80));
    step(1, 0, 8'h00);
    chk("to_drop_once", 64'(frame_drop), 64'(0));
    step(1, 1, 8'h02);
    chk("to_after_id", 64'(dut_stb()), 64'(S_ID));

    // Byte arriving on the would-be timeout edge is accepted.
    step(1, 1, 8'h81);
    step(1, 1, 8'hAA);
    for (int i = 1; i < TO; i++) step(1, 0, 8'h00);
    step(1, 1, 8'hBB);
    chk("edge_no_drop", 64'(frame_drop), 64'(0));
    step(1, 1, 8'hCC);
    step(1, 1, 8'hDD);
    chk("edge_size", 64'(dut_stb()), 64'(S_SIZ));
    chk("edge_cfg", 64'(config_data), 64'(32'hDDCCBBAA));

    // Random framing traffic with gaps straddling the timeout.
    for (int k = 0; k < 400; k++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        step(0, 1'($urandom_range(0, 1)), 8'($urandom));
      end else if (sel < 8) begin
        step(1, 1, 8'($urandom_range(0, 8'h7F)) & 8'h1F);
        for (int g = $urandom_range(0, 2); g > 0; g--) step(1, 0, 8'($urandom));
      end else begin
        int nb;
        nb = int'($urandom_range(0, 4));
        step(1, 1, 8'h80 | (sel < 12 ? 8'($urandom_range(0, 3)) : 8'h40 | 8'($urandom_range(0, 15))));
        for (int b = 0; b < nb; b++) begin
          for (int g = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : 0; g > 0; g--)
            step(1, 0, 8'($urandom));
          step(1, 1, 8'($urandom));
        end
        for (int g = $urandom_range(0, 18); g > 0; g--) step(1, 0, 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
